// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing one L2 line port between the I-cache and D-cache L1 miss paths.
// Optional per-port grant/wait performance counters are enabled with `define ARB_PERF_CNT_EN.
module l2_arbiter #(
    parameter int AW = 28,
    parameter int DW = 128,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          proc_reset_n,
    input  logic          i_read,
    input  logic          i_write,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic          i_ready,
    output logic [DW-1:0] i_rdata,
    input  logic          d_read,
    input  logic          d_write,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic [DW-1:0] d_rdata,
    output logic          L2_read,
    output logic          L2_write,
    output logic [AW-1:0] L2_addr,
    output logic [DW-1:0] L2_wdata,
    input  logic          L2_ready,
    input  logic [DW-1:0] L2_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [CW-1:0] cnt_grant_i,
    output logic [CW-1:0] cnt_grant_d,
    output logic [CW-1:0] cnt_wait_i,
    output logic [CW-1:0] cnt_wait_d
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUSY_I,
        ST_BUSY_D,
        ST_RESP_I,
        ST_RESP_D
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_last_d;
    logic            r_write;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rdata;
    logic            w_i_req;
    logic            w_d_req;
    logic            w_grant_i;
    logic            w_grant_d;
    logic            w_busy;

    // read and write together is malformed and never granted
    assign w_i_req = i_read ^ i_write;
    assign w_d_req = d_read ^ d_write;
    assign w_busy  = (r_state == ST_BUSY_I) || (r_state == ST_BUSY_D);

    always_comb begin
        w_next_state = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_i_req && (!w_d_req || r_last_d)) begin
                    w_grant_i    = 1'b1;
                    w_next_state = ST_BUSY_I;
                end else if (w_d_req) begin
                    w_grant_d    = 1'b1;
                    w_next_state = ST_BUSY_D;
                end
            end
            ST_BUSY_I: if (L2_ready) w_next_state = ST_RESP_I;
            ST_BUSY_D: if (L2_ready) w_next_state = ST_RESP_D;
            ST_RESP_I: w_next_state = ST_IDLE;
            ST_RESP_D: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) r_state <= ST_IDLE;
        else               r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_last_d <= 1'b1;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            if (w_grant_i) begin
                r_last_d <= 1'b0;
                r_write  <= i_write;
                r_addr   <= i_addr;
                r_wdata  <= i_wdata;
            end else if (w_grant_d) begin
                r_last_d <= 1'b1;
                r_write  <= d_write;
                r_addr   <= d_addr;
                r_wdata  <= d_wdata;
            end
            if (w_busy && L2_ready) r_rdata <= L2_rdata;
        end
    end

    // L2 strobes decode from state so reset drops them without a clock
    assign L2_read  = w_busy & ~r_write;
    assign L2_write = w_busy & r_write;
    assign L2_addr  = r_addr;
    assign L2_wdata = r_wdata;
    assign i_ready  = (r_state == ST_RESP_I);
    assign d_ready  = (r_state == ST_RESP_D);
    assign i_rdata  = r_rdata;
    assign d_rdata  = r_rdata;

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            cnt_grant_i <= '0;
            cnt_grant_d <= '0;
            cnt_wait_i  <= '0;
            cnt_wait_d  <= '0;
        end else begin
            cnt_grant_i <= cnt_grant_i + CW'(w_grant_i);
            cnt_grant_d <= cnt_grant_d + CW'(w_grant_d);
            cnt_wait_i  <= cnt_wait_i + CW'(w_i_req & ~i_ready);
            cnt_wait_d  <= cnt_wait_d + CW'(w_d_req & ~d_ready);
        end
    end
`endif

endmodule
